// File: rtl/fft8_frame_loader.sv
// Serial-to-parallel frame loader for the 8-point FFT.
// Collects 8 samples in bit-reversed order, sequences stage enables, holds the result.
module fft8_frame_loader #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] x3,
  output logic [DATA_W-1:0] x4,
  output logic [DATA_W-1:0] x5,
  output logic [DATA_W-1:0] x6,
  output logic [DATA_W-1:0] x7,
  output logic [3:0]        en_bf1,
  output logic [1:0]        en_bf2,
  output logic              en_bf3,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [2:0] {
    LOAD,
    ST1,
    ST2,
    ST3,
    RESULT
  } state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [2:0]        slot;
  logic [DATA_W-1:0] xr [8];

  assign s_ready = reset_n & ~flush & (state == LOAD);
  assign slot    = {cnt[0], cnt[1], cnt[2]};

  assign x0 = xr[0];
  assign x1 = xr[1];
  assign x2 = xr[2];
  assign x3 = xr[3];
  assign x4 = xr[4];
  assign x5 = xr[5];
  assign x6 = xr[6];
  assign x7 = xr[7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= LOAD;
      cnt       <= 3'd0;
      en_bf1    <= 4'd0;
      en_bf2    <= 2'd0;
      en_bf3    <= 1'b0;
      res_valid <= 1'b0;
      frame_cnt <= '0;
      for (int i = 0; i < 8; i++) xr[i] <= '0;
    end else if (flush) begin
      // x ports and frame_cnt deliberately keep their values
      state     <= LOAD;
      cnt       <= 3'd0;
      en_bf1    <= 4'd0;
      en_bf2    <= 2'd0;
      en_bf3    <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (s_valid) begin
            xr[slot] <= s_data;
            cnt      <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              state  <= ST1;
              en_bf1 <= 4'hf;
            end
          end
        end
        ST1: begin
          state  <= ST2;
          en_bf1 <= 4'd0;
          en_bf2 <= 2'b11;
        end
        ST2: begin
          state  <= ST3;
          en_bf2 <= 2'd0;
          en_bf3 <= 1'b1;
        end
        ST3: begin
          state     <= RESULT;
          en_bf3    <= 1'b0;
          res_valid <= 1'b1;
        end
        RESULT: begin
          if (res_ready) begin
            state     <= LOAD;
            res_valid <= 1'b0;
            frame_cnt <= frame_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= LOAD;
          cnt       <= 3'd0;
          en_bf1    <= 4'd0;
          en_bf2    <= 2'd0;
          en_bf3    <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fft8_frame_loader.md
Name: fft8_frame_loader

Overview:
- Upstream feeder for the 8-point FFT datapath.
- Accepts a serial stream of 16-bit time-domain samples over a valid/ready handshake and collects one 8-sample frame.
- Presents the frame in parallel on eight bit-reversed-order ports, then sequences the three butterfly-stage enables one stage per cycle.
- Signals result availability and holds the datapath frozen until the consumer acknowledges.

Parameters:
DATA_W, 16, sample width (two's complement)
CNT_W, 8, width of completed-frame counter

Ports:
clk  in  1  clock, all logic rising-edge
reset_n  in  1  synchronous active-low reset
flush  in  1  synchronous abort: discard partial/in-flight frame, return to LOAD
s_valid  in  1  input sample valid
s_data  in  DATA_W  input sample, arrival index k = 0..7 within frame
s_ready  out  1  loader can accept a sample
x0..x7  out  DATA_W each  parallel frame to FFT, bit-reversed order
en_bf1  out  4  stage-1 butterfly enables (bit i -> en_bf1_{i+1})
en_bf2  out  2  stage-2 butterfly enables
en_bf3  out  1  stage-3 butterfly enable
res_valid  out  1  FFT outputs valid and stable
res_ready  in  1  consumer accepts result
frame_cnt  out  CNT_W  number of completed result handshakes

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=LOAD, sample counter=0, x0..x7=0, en_*=0, res_valid=0, frame_cnt=0.
  - s_ready is forced 0 while reset_n is low.
- Mapping: sample k is written to port bitrev3(k).
  - x0=s0, x1=s4, x2=s2, x3=s6, x4=s1, x5=s5, x6=s3, x7=s7.
  - Port registers update only on an accepted beat; otherwise they hold.
- FSM states: LOAD, ST1, ST2, ST3, RESULT. Outputs are decoded from the registered state (no input-to-output combinational path except s_ready gating).
  - LOAD: s_ready=1.
    - Beat accepted when s_valid&s_ready; counter increments.
    - On the accepted beat with counter=7: counter->0, next state ST1.
    - s_valid low: no change, no bubbles counted.
  - ST1: en_bf1=4'b1111, all others 0, s_ready=0.
  - ST2: en_bf2=2'b11.
  - ST3: en_bf3=1.
  - RESULT: res_valid=1, all en_*=0 (FFT outputs frozen), s_ready=0.
    - On res_valid&res_ready: frame_cnt+1 (wraps 2^CNT_W-1 -> 0), next state LOAD.
- Latency: last beat accepted at edge T -> en_bf1 high in cycle T+1, en_bf2 in T+2, en_bf3 in T+3, res_valid from T+4.
  - With res_ready held high, the minimum frame period is 12 cycles: 8 load + 3 stage + 1 result.
- x0..x7 stay constant from ST1 through RESULT; the next frame overwrites them only after returning to LOAD.
- Exactly one enable group is active per cycle; en_bf1/en_bf2/en_bf3 are never simultaneously nonzero.
- flush (lower priority than reset, higher than everything else):
  - Next state LOAD, counter=0, en_*=0, res_valid=0.
  - x0..x7 hold their values; frame_cnt unchanged.
  - A beat presented in the same cycle as flush is dropped (not accepted).
- res_ready asserted outside RESULT has no effect.
- res_valid, once high, stays high until the handshake, flush, or reset.

Test Plan:
- Reset, then stream 501,604,230,-1015,2324,-304,-530,1715 with s_valid=1 every cycle -> x0..x7 = 501,2324,230,-530,604,-304,-1015,1715. Checks:
  - en_bf1=1111 one cycle after the 8th beat, then en_bf2=11, then en_bf3=1.
  - res_valid asserted 4 cycles after the last beat.
  - s_ready=0 from ST1 until the handshake.
- Second frame 1107,-11115,5400,-1015,-18700,-2504,-2709,2024 with s_valid toggling 1/0 -> exactly 8 beats accepted over 16 cycles; x-port mapping correct; first frame's x values held through its RESULT.
- Hold res_ready=0 for 5 cycles in RESULT -> res_valid stays 1, en_*=0, x0..x7 unchanged, s_ready=0; res_ready=1 -> frame_cnt increments by 1, s_ready=1 next cycle.
- Assert flush after 5 beats -> counter resets; the next 8 beats form a full frame (x1 = 5th new beat, etc.). Assert flush during ST2 -> en_bf2 drops next cycle, state LOAD, no res_valid, frame_cnt unchanged.
- Pull reset_n low mid-LOAD (3 beats in) and during RESULT -> after the next edge all outputs are at reset values and s_ready=0 while low; after release, a fresh frame completes normally.
- Run 256 back-to-back frames with res_ready=1 -> each period is 12 cycles, and frame_cnt wraps from 255 to 0 on the 256th handshake.
